settings_bus_arbiter: RTL and testbench



---
 rtl/settings_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_settings_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/settings_bus_arbiter.sv
// Settings bus arbiter: two queued writers share one serial settings bus, one strobe per grant.
// Build option SETTINGS_ARB_ROUND_ROBIN_EN replaces A-over-B priority with round-robin.
//
// state   | meaning
// S_IDLE  | waiting for a queued write; pops the winning FIFO head
// S_ISSUE | serial_strobe high for one cycle with the popped entry
// S_GAP   | forced idle cycles after a strobe
module settings_bus_arbiter #(
  parameter int DEPTH_LOG2 = 2,
  parameter int GAP        = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        strobe_a,
  input  logic [6:0]  addr_a,
  input  logic [31:0] data_a,
  input  logic        strobe_b,
  input  logic [6:0]  addr_b,
  input  logic [31:0] data_b,
  input  logic        clear_status,
  output logic        full_a,
  output logic        full_b,
  output logic        serial_strobe,
  output logic [6:0]  serial_addr,
  output logic [31:0] serial_data,
  output logic        busy,
  output logic [1:0]  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [3:0]            GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  state_t                state, state_next;
  logic [3:0]            gap_cnt;
  logic [38:0]           mem      [2][DEPTH];
  logic [38:0]           req_word [2];
  logic [DEPTH_LOG2-1:0] wr_ptr   [2];
  logic [DEPTH_LOG2-1:0] rd_ptr   [2];
  logic [CW-1:0]         cnt      [2];
  logic [CW-1:0]         cnt_next [2];
  logic [1:0]            req_strobe, push, pop, drop, nonempty, full_q;
  logic [38:0]           head_word;
  logic                  pick, grant_b;

  assign req_strobe  = {strobe_b, strobe_a};
  assign req_word[0] = {addr_a, data_a};
  assign req_word[1] = {addr_b, data_b};
  // full_q is the registered occupancy, so a push into a full FIFO drops even if it pops this cycle
  assign push     = req_strobe & ~full_q;
  assign drop     = req_strobe & full_q;
  assign nonempty = {cnt[1] != '0, cnt[0] != '0};
  assign pick     = (state == S_IDLE) && (nonempty != 2'b00);

`ifdef SETTINGS_ARB_ROUND_ROBIN_EN
  logic prefer_b;
  assign grant_b = nonempty[1] & (~nonempty[0] | prefer_b);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  prefer_b <= 1'b0;
    else if (pick) prefer_b <= ~grant_b;
  end
`else
  assign grant_b = ~nonempty[0];
`endif

  assign pop       = {pick & grant_b, pick & ~grant_b};
  assign head_word = grant_b ? mem[1][rd_ptr[1]] : mem[0][rd_ptr[0]];
  assign full_a    = full_q[0];
  assign full_b    = full_q[1];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_next[i] = cnt[i];
      if (push[i] && !pop[i])      cnt_next[i] = cnt[i] + CNT_ONE;
      else if (pop[i] && !push[i]) cnt_next[i] = cnt[i] - CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= req_word[i];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      full_q   <= 2'b00;
      overflow <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
        cnt[i]      <= cnt_next[i];
        full_q[i]   <= (cnt_next[i] == CNT_FULL);
        overflow[i] <= drop[i] | (overflow[i] & ~clear_status);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      gap_cnt     <= 4'd0;
      serial_addr <= 7'd0;
      serial_data <= 32'd0;
      busy        <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_ISSUE)                    gap_cnt <= GAP_LOAD;
      else if (state == S_GAP && gap_cnt != 0) gap_cnt <= gap_cnt - 4'd1;
      if (pick) {serial_addr, serial_data} <= head_word;
      busy <= (cnt_next[0] != '0) | (cnt_next[1] != '0) | (state_next != S_IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (pick) state_next = S_ISSUE;
      S_ISSUE: state_next = (GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_cnt == 4'd0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    serial_strobe = (state == S_ISSUE);
  end

endmodule

// File: tb/tb_settings_bus_arbiter.sv
// Bench for settings_bus_arbiter: GAP=1 and GAP=3 instances against a queue/timeline reference model.
module tb_settings_bus_arbiter;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n, strobe_a, strobe_b, clear_status;
  logic [6:0]  addr_a, addr_b;
  logic [31:0] data_a, data_b;

  logic        full_a0, full_b0, ss0, busy0, full_a1, full_b1, ss1, busy1;
  logic [6:0]  sa0, sa1;
  logic [31:0] sd0, sd1;
  logic [1:0]  ov0, ov1;

  always #5 clock = ~clock;

  settings_bus_arbiter #(.DEPTH_LOG2(2), .GAP(1)) u_dut0 (
    .clock(clock), .reset_n(reset_n),
    .strobe_a(strobe_a), .addr_a(addr_a), .data_a(data_a),
    .strobe_b(strobe_b), .addr_b(addr_b), .data_b(data_b),
    .clear_status(clear_status), .full_a(full_a0), .full_b(full_b0),
    .serial_strobe(ss0), .serial_addr(sa0), .serial_data(sd0),
    .busy(busy0), .overflow(ov0));

  settings_bus_arbiter #(.DEPTH_LOG2(2), .GAP(3)) u_dut1 (
    .clock(clock), .reset_n(reset_n),
    .strobe_a(strobe_a), .addr_a(addr_a), .data_a(data_a),
    .strobe_b(strobe_b), .addr_b(addr_b), .data_b(data_b),
    .clear_status(clear_status), .full_a(full_a1), .full_b(full_b1),
    .serial_strobe(ss1), .serial_addr(sa1), .serial_data(sd1),
    .busy(busy1), .overflow(ov1));

  int checks = 0;
  int errors = 0;

  // Reference model: per instance, two FIFOs as circular arrays plus the edge at which
  // the arbiter may next grant (a grant at edge e blocks grants until e + 2 + gap).
  logic [38:0] mf [2][2][DEPTH];
  int          mh [2][2];
  int          mc [2][2];
  int          next_pick [2];
  bit          pref_b [2];
  logic [1:0]  m_ovf [2];
  logic [38:0] m_last [2];
  bit          m_strobe [2];
  bit          m_busy [2];
  int          edge_n = 0;
  logic [6:0]  obs_addr [$];
  int          obs_edge [$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < 2; s++) begin
        mh[i][s] = 0;
        mc[i][s] = 0;
      end
      next_pick[i] = 0;
      pref_b[i]    = 1'b0;
      m_ovf[i]     = 2'b00;
      m_last[i]    = '0;
      m_strobe[i]  = 1'b0;
      m_busy[i]    = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [38:0] w [2];
    logic [1:0]  st, set;
    bit          full_pre [2];
    int          s;
    w[0] = {addr_a, data_a};
    w[1] = {addr_b, data_b};
    st   = {strobe_b, strobe_a};
    for (int i = 0; i < 2; i++) begin
      set = 2'b00;
      for (int k = 0; k < 2; k++) full_pre[k] = (mc[i][k] == DEPTH);
      m_strobe[i] = 1'b0;
      if (edge_n >= next_pick[i] && (mc[i][0] > 0 || mc[i][1] > 0)) begin
        if (mc[i][0] == 0)      s = 1;
        else if (mc[i][1] == 0) s = 0;
        else begin
`ifdef SETTINGS_ARB_ROUND_ROBIN_EN
          s = pref_b[i] ? 1 : 0;
`else
          s = 0;
`endif
        end
        pref_b[i]    = (s == 0);
        m_last[i]    = mf[i][s][mh[i][s]];
        mh[i][s]     = (mh[i][s] + 1) % DEPTH;
        mc[i][s]     = mc[i][s] - 1;
        m_strobe[i]  = 1'b1;
        next_pick[i] = edge_n + 2 + gap_of(i);
      end
      for (int k = 0; k < 2; k++) begin
        if (st[k]) begin
          if (full_pre[k]) set[k] = 1'b1;
          else begin
            mf[i][k][(mh[i][k] + mc[i][k]) % DEPTH] = w[k];
            mc[i][k] = mc[i][k] + 1;
          end
        end
      end
      m_ovf[i]  = set | (m_ovf[i] & ~{2{clear_status}});
      m_busy[i] = (mc[i][0] > 0) || (mc[i][1] > 0) || (edge_n + 1 < next_pick[i]);
    end
    edge_n++;
  endtask

  function automatic logic [63:0] exp_vec(input int i);
    return {19'd0, m_strobe[i], m_last[i], mc[i][0] == DEPTH, mc[i][1] == DEPTH, m_busy[i], m_ovf[i]};
  endfunction

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check_val("cyc_dut0", {19'd0, ss0, sa0, sd0, full_a0, full_b0, busy0, ov0}, exp_vec(0));
    check_val("cyc_dut1", {19'd0, ss1, sa1, sd1, full_a1, full_b1, busy1, ov1}, exp_vec(1));
    if (ss0) begin
      obs_addr.push_back(sa0);
      obs_edge.push_back(edge_n);
    end
  endtask

  task automatic quiet();
    strobe_a = 1'b0; strobe_b = 1'b0; clear_status = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    quiet();
    addr_a = '0; data_a = '0; addr_b = '0; data_b = '0;
    repeat (3) @(posedge clock);
    #1;
    check_val("reset_dut0", {ss0, sa0, sd0, full_a0, full_b0, busy0, ov0}, 64'd0);
    check_val("reset_dut1", {ss1, sa1, sd1, full_a1, full_b1, busy1, ov1}, 64'd0);
    model_reset();
    reset_n = 1'b1;

    // single write latency
    strobe_a = 1'b1; addr_a = 7'd38; data_a = 32'h0000_00AB;
    step();
    quiet();
    step();
    check_val("single_strobe", ss0, 1);
    check_val("single_addr", sa0, 38);
    check_val("single_data", sd0, 32'hAB);
    run(2);
    check_val("single_busy_clear", busy0, 0);
    run(4);

    // same-cycle collision
    obs_addr.delete(); obs_edge.delete();
    strobe_a = 1'b1; addr_a = 7'd5; data_a = 32'd1;
    strobe_b = 1'b1; addr_b = 7'd9; data_b = 32'd2;
    step();
    quiet();
    run(10);
    check_val("coll_count", obs_addr.size(), 2);
    check_val("coll_first", obs_addr[0], 5);
    check_val("coll_second", obs_addr[1], 9);
    check_val("coll_spacing", obs_edge[1] - obs_edge[0], 3);
    check_val("coll_ovf", ov0, 0);

    // B overflow while A holds the arbiter
    obs_addr.delete(); obs_edge.delete();
    for (int k = 0; k < 6; k++) begin
      strobe_a = (k < 3); addr_a = 7'(10 + k); data_a = 32'(k);
      strobe_b = 1'b1;    addr_b = 7'(20 + k); data_b = 32'(100 + k);
      step();
    end
    quiet();
    check_val("ovf_full_b", full_b0, 1);
    check_val("ovf_flags", ov0, 2'b10);
    run(30);
    n = 0;
    foreach (obs_addr[k]) if (obs_addr[k] >= 7'd20) begin
      check_val("ovf_b_order", obs_addr[k], 7'(20 + n));
      n++;
    end
    check_val("ovf_b_count", n, 4);
    clear_status = 1'b1;
    step();
    quiet();
    check_val("ovf_cleared", ov0, 0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      strobe_a = ($urandom_range(0, 2) == 0);
      strobe_b = ($urandom_range(0, 2) == 0);
      addr_a = 7'($urandom); data_a = $urandom;
      addr_b = 7'($urandom); data_b = $urandom;
      clear_status = ($urandom_range(0, 15) == 0);
      step();
    end
    quiet();
    run(50);

    // reset during ISSUE
    for (int k = 0; k < 3; k++) begin
      strobe_a = 1'b1; addr_a = 7'(70 + k); data_a = 32'(k);
      step();
    end
    quiet();
    n = 0;
    while (!ss0 && n < 10) begin
      step();
      n++;
    end
    check_val("rst_reach_issue", ss0, 1);
    reset_n = 1'b0;
    #1;
    check_val("rst_mid_dut0", {ss0, sa0, sd0, full_a0, full_b0, busy0, ov0}, 64'd0);
    check_val("rst_mid_dut1", {ss1, sa1, sd1, full_a1, full_b1, busy1, ov1}, 64'd0);
    #1;
    reset_n = 1'b1;
    model_reset();
    obs_addr.delete(); obs_edge.delete();
    run(12);
    check_val("rst_no_strobe", obs_addr.size(), 0);
    check_val("rst_busy", busy0, 0);

    // simultaneous A and B backlog: grant order
    for (int k = 0; k < 4; k++) begin
      strobe_a = 1'b1; addr_a = 7'(40 + k); data_a = 32'(k);
      strobe_b = 1'b1; addr_b = 7'(60 + k); data_b = 32'(k);
      step();
    end
    quiet();
    run(30);
    check_val("order_count", obs_addr.size(), 8);
    for (int k = 0; k < 8; k++) begin
`ifdef SETTINGS_ARB_ROUND_ROBIN_EN
      check_val("order_rr", obs_addr[k], 7'(((k % 2) == 0 ? 40 : 60) + k / 2));
`else
      check_val("order_fixed", obs_addr[k], 7'((k < 4) ? 40 + k : 56 + k));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
